// File: rtl/yuv422_rgb_stream.sv
// rtl/yuv422_rgb_stream.sv - streaming YUYV word to RGB pixel converter with valid/ready flow control
// Holder (word + pixel select) -> stage A (pre-clamp sums) -> output register, all on one advance enable.
module yuv422_rgb_stream #(
  parameter int CW       = 3,
  parameter int PIX_MODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_yuv,
  input  logic            in_sof,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3*CW-1:0] out_rgb,
  output logic            out_sof,
  output logic            out_odd
);
  typedef logic signed [19:0] sum_t;

  logic            hold_v_q, hold_v_d;
  logic [31:0]     hold_word_q, hold_word_d;
  logic            hold_sof_q, hold_sof_d;
  logic            sel_q, sel_d;
  logic            a_v_q, a_v_d;
  sum_t            a_r_q, a_r_d, a_g_q, a_g_d, a_b_q, a_b_d;
  logic            a_sof_q, a_sof_d;
  logic            a_odd_q, a_odd_d;
  logic            out_valid_q, out_valid_d;
  logic [3*CW-1:0] out_rgb_q, out_rgb_d;
  logic            out_sof_q, out_sof_d;
  logic            out_odd_q, out_odd_d;

  logic            en, last, first, accept;
  logic [7:0]      y_sel;
  sum_t            c, d, e;

  function automatic logic [CW-1:0] clamp_ch(input sum_t v);
    logic [15:0] m;
    if (v < 0) m = 16'h0000;
    else if (v >= sum_t'(65536)) m = 16'hFF00;
    else m = v[15:0];
    return m[15 -: CW];
  endfunction

  assign en       = ~out_valid_q | out_ready;
  assign last     = (PIX_MODE == 1) ? 1'b1 : sel_q;
  assign first    = (PIX_MODE == 1) ? 1'b1 : ~sel_q;
  assign in_ready = rst_n & en & (~hold_v_q | last);
  assign accept   = in_valid & in_ready;

  // U and V are shared by both pixels; only the luma sample changes with sel.
  assign y_sel = last ? hold_word_q[23:16] : hold_word_q[7:0];
  assign c     = $signed({12'd0, y_sel}) - sum_t'(16);
  assign d     = $signed({12'd0, hold_word_q[15:8]}) - sum_t'(128);
  assign e     = $signed({12'd0, hold_word_q[31:24]}) - sum_t'(128);

  always_comb begin
    hold_v_d    = hold_v_q;
    hold_word_d = hold_word_q;
    hold_sof_d  = hold_sof_q;
    sel_d       = sel_q;
    a_v_d       = a_v_q;
    a_r_d       = a_r_q;
    a_g_d       = a_g_q;
    a_b_d       = a_b_q;
    a_sof_d     = a_sof_q;
    a_odd_d     = a_odd_q;
    out_valid_d = out_valid_q;
    out_rgb_d   = out_rgb_q;
    out_sof_d   = out_sof_q;
    out_odd_d   = out_odd_q;
    if (en) begin
      a_v_d = hold_v_q;
      if (hold_v_q) begin
        a_r_d   = sum_t'(256) * c + sum_t'(291) * e + sum_t'(128);
        a_g_d   = sum_t'(256) * c - sum_t'(100) * d - sum_t'(148) * e + sum_t'(128);
        a_b_d   = sum_t'(256) * c + sum_t'(520) * d + sum_t'(128);
        a_sof_d = hold_sof_q & first;
        a_odd_d = last;
      end
      out_valid_d = a_v_q;
      if (a_v_q) begin
        out_rgb_d = {clamp_ch(a_r_q), clamp_ch(a_g_q), clamp_ch(a_b_q)};
        out_sof_d = a_sof_q;
        out_odd_d = a_odd_q;
      end
      // The holder frees on its last pixel and may be refilled on that same edge.
      if (hold_v_q && !last) begin
        sel_d = 1'b1;
      end else begin
        sel_d    = (PIX_MODE == 1);
        hold_v_d = accept;
        if (accept) begin
          hold_word_d = in_yuv;
          hold_sof_d  = in_sof;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v_q    <= 1'b0;
      hold_word_q <= '0;
      hold_sof_q  <= 1'b0;
      sel_q       <= 1'b0;
      a_v_q       <= 1'b0;
      a_r_q       <= '0;
      a_g_q       <= '0;
      a_b_q       <= '0;
      a_sof_q     <= 1'b0;
      a_odd_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_rgb_q   <= '0;
      out_sof_q   <= 1'b0;
      out_odd_q   <= 1'b0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_word_q <= hold_word_d;
      hold_sof_q  <= hold_sof_d;
      sel_q       <= sel_d;
      a_v_q       <= a_v_d;
      a_r_q       <= a_r_d;
      a_g_q       <= a_g_d;
      a_b_q       <= a_b_d;
      a_sof_q     <= a_sof_d;
      a_odd_q     <= a_odd_d;
      out_valid_q <= out_valid_d;
      out_rgb_q   <= out_rgb_d;
      out_sof_q   <= out_sof_d;
      out_odd_q   <= out_odd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_rgb   = out_rgb_q;
  assign out_sof   = out_sof_q;
  assign out_odd   = out_odd_q;
endmodule
